nco_sweep_ctrl: RTL and testbench

//  Sequencer in front of the NCO. Drives the NCO phase-increment input and

---
 rtl/nco_sweep_ctrl_if.sv | 32 +++
 rtl/nco_sweep_ctrl.sv | 171 +++++++++++++++++
 tb/tb_nco_sweep_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/nco_sweep_ctrl_if.sv
// Control and NCO-facing signal bundle for the NCO sweep sequencer.
// The master side supplies sweep commands/configuration; the slave side
// (the sequencer) drives the NCO controls and sweep status.
interface nco_sweep_ctrl_if #(
  parameter int APR = 32,
  parameter int NCW = 16,
  parameter int DWW = 16
);
  logic           start;
  logic           abort;
  logic [APR-1:0] f_start;
  logic [APR-1:0] f_step;
  logic [NCW-1:0] n_steps;
  logic [DWW-1:0] dwell;
  logic           loop_en;
  logic [APR-1:0] phi_inc_o;
  logic           nco_clken;
  logic [NCW-1:0] step_idx;
  logic           busy;
  logic           sweep_valid;
  logic           done;

  modport master (
    output start, abort, f_start, f_step, n_steps, dwell, loop_en,
    input  phi_inc_o, nco_clken, step_idx, busy, sweep_valid, done
  );

  modport slave (
    input  start, abort, f_start, f_step, n_steps, dwell, loop_en,
    output phi_inc_o, nco_clken, step_idx, busy, sweep_valid, done
  );
endinterface

// File: rtl/nco_sweep_ctrl.sv
// Stepped-frequency sweep sequencer in front of an NCO.
// Holds each phase increment for max(dwell,1) cycles, optionally loops,
// flushes the NCO pipeline for NCO_LAT cycles after the last step and marks
// which NCO output samples belong to the sweep. All outputs are registered.
module nco_sweep_ctrl #(
  parameter int APR     = 32,
  parameter int NCW     = 16,
  parameter int DWW     = 16,
  parameter int NCO_LAT = 12
) (
  input  logic             clk,
  input  logic             reset,
  nco_sweep_ctrl_if.slave  bus
);

  localparam int LW = $clog2(NCO_LAT + 1);
  localparam logic [LW-1:0] LAT_MAX = LW'(NCO_LAT);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH} state_t;

  state_t         state_reg, state_next;
  logic [APR-1:0] f_start_reg, f_start_next;
  logic [APR-1:0] f_step_reg, f_step_next;
  logic [NCW-1:0] n_steps_reg, n_steps_next;
  logic [DWW-1:0] dwell_reg, dwell_next;       // effective dwell, never 0
  logic [APR-1:0] phi_reg, phi_next;
  logic [NCW-1:0] step_reg, step_next;
  logic [DWW-1:0] dwell_cnt_reg, dwell_cnt_next;
  logic [LW-1:0]  lat_cnt_reg, lat_cnt_next;   // clken cycles since RUN entry, saturating
  logic [LW-1:0]  flush_cnt_reg, flush_cnt_next;
  logic           clken_reg, clken_next;
  logic           busy_reg, busy_next;
  logic           valid_reg, valid_next;
  logic           done_reg, done_next;

  logic           last_step;
  logic           dwell_exp;

  assign last_step = (step_reg == n_steps_reg - NCW'(1));
  assign dwell_exp = (dwell_cnt_reg == dwell_reg - DWW'(1));

  // Next-state and next-output logic; abort overrides everything and a
  // start that coincides with abort is dropped without touching config.
  always_comb begin
    state_next     = state_reg;
    f_start_next   = f_start_reg;
    f_step_next    = f_step_reg;
    n_steps_next   = n_steps_reg;
    dwell_next     = dwell_reg;
    phi_next       = phi_reg;
    step_next      = step_reg;
    dwell_cnt_next = dwell_cnt_reg;
    lat_cnt_next   = lat_cnt_reg;
    flush_cnt_next = flush_cnt_reg;
    done_next      = 1'b0;

    if (bus.abort) begin
      state_next = ST_IDLE;
    end else begin
      // clken is high throughout RUN and FLUSH, so count every busy cycle
      if (state_reg != ST_IDLE && lat_cnt_reg != LAT_MAX)
        lat_cnt_next = lat_cnt_reg + LW'(1);

      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            f_start_next = bus.f_start;
            f_step_next  = bus.f_step;
            n_steps_next = bus.n_steps;
            dwell_next   = (bus.dwell == '0) ? DWW'(1) : bus.dwell;
            if (bus.n_steps != '0) begin
              state_next     = ST_RUN;
              phi_next       = bus.f_start;
              step_next      = '0;
              dwell_cnt_next = '0;
              lat_cnt_next   = '0;
            end else begin
              done_next = 1'b1;
            end
          end
        end

        ST_RUN: begin
          if (dwell_exp) begin
            dwell_cnt_next = '0;
            if (!last_step) begin
              phi_next  = phi_reg + f_step_reg;
              step_next = step_reg + NCW'(1);
            end else if (bus.loop_en) begin
              // looping is decided by the live loop_en at the last step
              phi_next  = f_start_reg;
              step_next = '0;
            end else begin
              state_next     = ST_FLUSH;
              flush_cnt_next = '0;
            end
          end else begin
            dwell_cnt_next = dwell_cnt_reg + DWW'(1);
          end
        end

        ST_FLUSH: begin
          if (flush_cnt_reg == LAT_MAX - LW'(1)) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end else begin
            flush_cnt_next = flush_cnt_reg + LW'(1);
          end
        end

        default: state_next = ST_IDLE;
      endcase
    end

    if (state_next == ST_IDLE)
      lat_cnt_next = '0;

    clken_next = (state_next != ST_IDLE);
    busy_next  = (state_next != ST_IDLE);
    valid_next = (state_next != ST_IDLE) && (lat_cnt_next == LAT_MAX);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset)
      state_reg <= ST_IDLE;
    else
      state_reg <= state_next;
  end

  // Configuration, datapath, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      f_start_reg   <= '0;
      f_step_reg    <= '0;
      n_steps_reg   <= '0;
      dwell_reg     <= '0;
      phi_reg       <= '0;
      step_reg      <= '0;
      dwell_cnt_reg <= '0;
      lat_cnt_reg   <= '0;
      flush_cnt_reg <= '0;
      clken_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      valid_reg     <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      f_start_reg   <= f_start_next;
      f_step_reg    <= f_step_next;
      n_steps_reg   <= n_steps_next;
      dwell_reg     <= dwell_next;
      phi_reg       <= phi_next;
      step_reg      <= step_next;
      dwell_cnt_reg <= dwell_cnt_next;
      lat_cnt_reg   <= lat_cnt_next;
      flush_cnt_reg <= flush_cnt_next;
      clken_reg     <= clken_next;
      busy_reg      <= busy_next;
      valid_reg     <= valid_next;
      done_reg      <= done_next;
    end
  end

  assign bus.phi_inc_o   = phi_reg;
  assign bus.nco_clken   = clken_reg;
  assign bus.step_idx    = step_reg;
  assign bus.busy        = busy_reg;
  assign bus.sweep_valid = valid_reg;
  assign bus.done        = done_reg;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Directed bench for the NCO sweep sequencer (NCO_LAT = 12).
module tb_nco_sweep_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  int   n;
  int   seen;

  always #5 clk = ~clk;

  nco_sweep_ctrl_if #(.APR(32), .NCW(16), .DWW(16)) bus ();

  nco_sweep_ctrl #(.APR(32), .NCW(16), .DWW(16), .NCO_LAT(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [31:0] fs, input logic [31:0] st,
                          input logic [15:0] ns, input logic [15:0] dw, input logic lp);
    bus.f_start = fs;
    bus.f_step  = st;
    bus.n_steps = ns;
    bus.dwell   = dw;
    bus.loop_en = lp;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
    $display("start f_start=%08h f_step=%08h n_steps=%0d dwell=%0d loop=%0b", fs, st, ns, dw, lp);
  endtask

  // ticks until done is seen or bound cycles elapse; returns ticks taken
  task automatic wait_done(input int bound, output int cnt);
    cnt = 0;
    while (bus.done !== 1'b1 && cnt < bound) begin
      tick();
      cnt++;
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_phi"},   64'(bus.phi_inc_o), 64'h0);
    chk({tag, "_step"},  64'(bus.step_idx), 64'h0);
    chk({tag, "_clken"}, 64'(bus.nco_clken), 64'h0);
    chk({tag, "_busy"},  64'(bus.busy), 64'h0);
    chk({tag, "_valid"}, 64'(bus.sweep_valid), 64'h0);
    chk({tag, "_done"},  64'(bus.done), 64'h0);
  endtask

  logic [31:0] t1_phi  [12] = '{32'h1000, 32'h1000, 32'h1000, 32'h1000,
                                32'h1100, 32'h1100, 32'h1100, 32'h1100,
                                32'h1200, 32'h1200, 32'h1200, 32'h1200};
  logic [15:0] t1_step [12] = '{0,0,0,0, 1,1,1,1, 2,2,2,2};
  logic [31:0] t3_phi  [12] = '{32'h5000, 32'h5000, 32'h5800, 32'h5800,
                                32'h5000, 32'h5000, 32'h5800, 32'h5800,
                                32'h5000, 32'h5000, 32'h5800, 32'h5800};

  initial begin
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.f_start = '0;
    bus.f_step  = '0;
    bus.n_steps = '0;
    bus.dwell   = '0;
    bus.loop_en = 1'b0;
    tick();
    tick();
    chk_idle_zero("reset");
    reset = 1'b0;
    tick();
    $display("reset checked");

    // 1. basic sweep
    do_start(32'h1000, 32'h100, 16'd3, 16'd4, 1'b0);
    for (int k = 0; k < 12; k++) begin
      chk("t1_run_phi",   64'(bus.phi_inc_o), 64'(t1_phi[k]));
      chk("t1_run_step",  64'(bus.step_idx), 64'(t1_step[k]));
      chk("t1_run_clken", 64'(bus.nco_clken), 64'h1);
      chk("t1_run_busy",  64'(bus.busy), 64'h1);
      chk("t1_run_valid", 64'(bus.sweep_valid), 64'h0);
      tick();
    end
    for (int k = 12; k < 24; k++) begin
      chk("t1_flush_phi",   64'(bus.phi_inc_o), 64'h1200);
      chk("t1_flush_clken", 64'(bus.nco_clken), 64'h1);
      chk("t1_flush_valid", 64'(bus.sweep_valid), 64'h1);
      chk("t1_flush_done",  64'(bus.done), 64'h0);
      tick();
    end
    chk("t1_done",      64'(bus.done), 64'h1);
    chk("t1_end_clken", 64'(bus.nco_clken), 64'h0);
    chk("t1_end_busy",  64'(bus.busy), 64'h0);
    chk("t1_end_valid", 64'(bus.sweep_valid), 64'h0);
    chk("t1_end_phi",   64'(bus.phi_inc_o), 64'h1200);
    tick();
    chk("t1_done_pulse", 64'(bus.done), 64'h0);
    $display("test1 basic sweep complete");

    // 2. wrap-around and negative step
    do_start(32'hFFFFFF00, 32'h200, 16'd2, 16'd1, 1'b0);
    chk("t2a_phi0", 64'(bus.phi_inc_o), 64'hFFFFFF00);
    tick();
    chk("t2a_phi1", 64'(bus.phi_inc_o), 64'h00000100);
    chk("t2a_step1", 64'(bus.step_idx), 64'h1);
    wait_done(40, n);
    chk("t2a_done_lat", 64'(n), 64'd13);
    chk("t2a_hold_phi", 64'(bus.phi_inc_o), 64'h00000100);
    tick();
    do_start(32'h100, 32'hFFFFFF00, 16'd2, 16'd1, 1'b0);
    chk("t2b_phi0", 64'(bus.phi_inc_o), 64'h100);
    tick();
    chk("t2b_phi1", 64'(bus.phi_inc_o), 64'h0);
    wait_done(40, n);
    chk("t2b_done_lat", 64'(n), 64'd13);
    tick();
    $display("test2 wrap/negative step complete");

    // 3. looping, then loop_en cleared
    do_start(32'h5000, 32'h800, 16'd2, 16'd2, 1'b1);
    for (int k = 0; k < 12; k++) begin
      chk("t3_phi",   64'(bus.phi_inc_o), 64'(t3_phi[k]));
      chk("t3_clken", 64'(bus.nco_clken), 64'h1);
      chk("t3_valid", 64'(bus.sweep_valid), 64'h0);
      if (k == 8) bus.loop_en = 1'b0;
      tick();
    end
    chk("t3_flush_phi",   64'(bus.phi_inc_o), 64'h5800);
    chk("t3_flush_step",  64'(bus.step_idx), 64'h1);
    chk("t3_flush_valid", 64'(bus.sweep_valid), 64'h1);
    wait_done(40, n);
    chk("t3_done_lat", 64'(n), 64'd12);
    tick();
    $display("test3 loop complete");

    // 4. degenerate configs
    do_start(32'h1234, 32'h1, 16'd0, 16'd5, 1'b0);
    chk("t4_nsteps0_done",  64'(bus.done), 64'h1);
    chk("t4_nsteps0_busy",  64'(bus.busy), 64'h0);
    chk("t4_nsteps0_clken", 64'(bus.nco_clken), 64'h0);
    chk("t4_nsteps0_phi",   64'(bus.phi_inc_o), 64'h5800);
    tick();
    chk("t4_nsteps0_pulse", 64'(bus.done), 64'h0);
    chk("t4_nsteps0_busy2", 64'(bus.busy), 64'h0);
    do_start(32'h10, 32'h10, 16'd3, 16'd0, 1'b0);
    chk("t4_dw0_phi0", 64'(bus.phi_inc_o), 64'h10);
    tick();
    chk("t4_dw0_phi1", 64'(bus.phi_inc_o), 64'h20);
    tick();
    chk("t4_dw0_phi2", 64'(bus.phi_inc_o), 64'h30);
    tick();
    chk("t4_dw0_flush_phi",  64'(bus.phi_inc_o), 64'h30);
    chk("t4_dw0_flush_busy", 64'(bus.busy), 64'h1);
    wait_done(40, n);
    chk("t4_dw0_done_lat", 64'(n), 64'd12);
    tick();
    $display("test4 degenerate configs complete");

    // 5a. abort at step 1 of 3
    do_start(32'h2000, 32'h100, 16'd3, 16'd3, 1'b0);
    tick(); tick(); tick();
    chk("t5_pre_abort_phi", 64'(bus.phi_inc_o), 64'h2100);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("t5_abort_clken", 64'(bus.nco_clken), 64'h0);
    chk("t5_abort_busy",  64'(bus.busy), 64'h0);
    chk("t5_abort_valid", 64'(bus.sweep_valid), 64'h0);
    chk("t5_abort_done",  64'(bus.done), 64'h0);
    chk("t5_abort_phi",   64'(bus.phi_inc_o), 64'h2100);
    chk("t5_abort_step",  64'(bus.step_idx), 64'h1);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
      tick();
    end
    chk("t5_abort_quiet", 64'(seen), 64'd0);
    $display("test5a abort complete");

    // 5b. reset during FLUSH while sweep_valid is high
    do_start(32'h3000, 32'h10, 16'd2, 16'd1, 1'b0);
    for (int k = 0; k < 12; k++) tick();
    chk("t5_flush_valid", 64'(bus.sweep_valid), 64'h1);
    reset = 1'b1;
    tick();
    chk_idle_zero("t5_reset");
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.done === 1'b1) seen++;
      tick();
    end
    chk("t5_reset_nodone", 64'(seen), 64'd0);
    $display("test5b reset mid-flush complete");

    // 5c. start together with abort in IDLE
    bus.f_start = 32'h7777;
    bus.n_steps = 16'd2;
    bus.dwell   = 16'd1;
    bus.start   = 1'b1;
    bus.abort   = 1'b1;
    tick();
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    chk_idle_zero("t5_startabort");
    tick();
    chk("t5_startabort_busy2", 64'(bus.busy), 64'h0);
    $display("test5c start+abort complete");

    // 6. start while busy is ignored
    do_start(32'h1000, 32'h100, 16'd2, 16'd2, 1'b0);
    chk("t6_phi0", 64'(bus.phi_inc_o), 64'h1000);
    tick();
    bus.f_start = 32'h9000;
    bus.f_step  = 32'h1;
    bus.n_steps = 16'd5;
    bus.dwell   = 16'd7;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
    chk("t6_phi2", 64'(bus.phi_inc_o), 64'h1100);
    chk("t6_step2", 64'(bus.step_idx), 64'h1);
    tick();
    chk("t6_phi3", 64'(bus.phi_inc_o), 64'h1100);
    tick();
    chk("t6_flush_phi",  64'(bus.phi_inc_o), 64'h1100);
    chk("t6_flush_busy", 64'(bus.busy), 64'h1);
    wait_done(40, n);
    chk("t6_done_lat", 64'(n), 64'd12);
    $display("test6 start while busy complete");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
